// File: rtl/pad_in_filter.sv
// pad_in_filter: per-pad 2-flop synchroniser, glitch filter and rise/fall event pulses
`timescale 1ns/1ps
module pad_in_filter #(
  parameter int Width    = 8,
  parameter int CntWidth = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [Width-1:0]    in_i,
  input  logic [Width-1:0]    filter_en_i,
  input  logic [CntWidth-1:0] thresh_i,
  output logic [Width-1:0]    in_o,
  output logic [Width-1:0]    rise_o,
  output logic [Width-1:0]    fall_o
);
  logic [Width-1:0] s1, s2, prev, filt, rise, fall, stable, next_filt;
  logic [CntWidth-1:0] cnt [Width];
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1   <= '0;
      s2   <= '0;
      prev <= '0;
      filt <= '0;
      rise <= '0;
      fall <= '0;
    end else begin
      s1   <= in_i;
      s2   <= s1;
      prev <= s2;
      filt <= next_filt;
      rise <= next_filt & ~filt;
      fall <= ~next_filt & filt;
    end
  end
  // Bypassed channels follow s2; filtered ones only move once s2 has been stable long enough.
  always_comb next_filt = ((~filter_en_i | stable) & s2) | ((filter_en_i & ~stable) & filt);
  for (genvar g = 0; g < Width; g++) begin : g_ch
    assign stable[g] = (s2[g] == prev[g]) && (cnt[g] >= thresh_i);
    // Saturating run-length counter of equal consecutive synced samples.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) cnt[g] <= '0;
      else if (s2[g] != prev[g]) cnt[g] <= '0;
      else if (cnt[g] != '1) cnt[g] <= cnt[g] + 1'b1;
    end
  end
  assign in_o   = filt;
  assign rise_o = rise;
  assign fall_o = fall;
endmodule
